router_1xn: RTL

ROUTER_1XN -- requirements
Module: router_1xn

---
 rtl/router_1xn.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/router_1xn.sv
// 1-to-N packet router: a header/payload/parity parser feeding one FWFT FIFO per output,
// with a per-port timeout that flushes FIFOs nobody is reading.
module router_1xn #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          valid_out,
  output logic                          busy,
  output logic                          err,
  output logic                          drop
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_DECODE, S_LOAD, S_PARITY, S_DISCARD} state_t;

  state_t              r_state;
  logic [1:0]          r_dest;
  logic [6:0]          r_cnt;
  logic [DATA_W-1:0]   r_parity;
  logic                r_err;
  logic                r_drop;

  logic [DATA_W-1:0]   r_mem  [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0]       r_wptr [NUM_PORTS];
  logic [PW-1:0]       r_rptr [NUM_PORTS];
  logic [TW-1:0]       r_tmo  [NUM_PORTS];

  logic [PW-1:0]        w_count [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_full, w_valid, w_flush, w_wr, w_rd;
  logic [3:0]           w_full4, w_flush4;
  logic [1:0]           w_hdr_dest, w_wr_dest;
  logic [5:0]           w_hdr_len;
  logic                 w_hdr_ok, w_busy, w_acc, w_wr_any;

  // Per-port FIFO status and timeout expiry
  always_comb begin
    w_full  = '0;
    w_valid = '0;
    w_flush = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_count[i] = r_wptr[i] - r_rptr[i];
      w_full[i]  = (w_count[i] == PW'(FIFO_DEPTH));
      w_valid[i] = (w_count[i] != '0);
      w_flush[i] = (r_tmo[i] == TW'(TIMEOUT));
    end
  end

  assign w_full4    = 4'(w_full);
  assign w_flush4   = 4'(w_flush);
  assign w_hdr_dest = data_in[1:0];
  assign w_hdr_len  = data_in[7:2];
  assign w_hdr_ok   = (32'(w_hdr_dest) < NUM_PORTS) && (w_hdr_len != '0);

  // Back-pressure only when the word is headed for a full FIFO
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_DECODE:         w_busy = pkt_valid && w_hdr_ok && w_full4[w_hdr_dest];
      S_LOAD, S_PARITY: w_busy = w_full4[r_dest];
      default:          w_busy = 1'b0;
    endcase
  end

  assign w_acc     = pkt_valid && !w_busy;
  assign w_wr_dest = (r_state == S_DECODE) ? w_hdr_dest : r_dest;
  assign w_wr_any  = w_acc && (((r_state == S_DECODE) && w_hdr_ok) ||
                               (r_state == S_LOAD) || (r_state == S_PARITY));

  // A flush overrides any write or read on the same FIFO
  always_comb begin
    w_wr = '0;
    w_rd = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_wr[i] = w_wr_any && (w_wr_dest == 2'(i)) && !w_flush[i];
      w_rd[i] = read_enb[i] && w_valid[i] && !w_flush[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_wr[i]) r_mem[i][r_wptr[i][AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_tmo[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (w_flush[i]) begin
          r_wptr[i] <= '0;
          r_rptr[i] <= '0;
          r_tmo[i]  <= '0;
        end else begin
          if (w_wr[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
          if (w_rd[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
          if (w_valid[i] && !read_enb[i]) r_tmo[i] <= r_tmo[i] + 1'b1;
          else                            r_tmo[i] <= '0;
        end
      end
    end
  end

  // Packet parser; r_cnt holds payload words left in LOAD, words left to swallow in DISCARD
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_DECODE;
      r_dest   <= '0;
      r_cnt    <= '0;
      r_parity <= '0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
      case (r_state)
        S_DECODE: begin
          if (w_acc) begin
            r_dest   <= w_hdr_dest;
            r_parity <= data_in;
            if (w_hdr_ok && !w_flush4[w_hdr_dest]) begin
              r_cnt   <= 7'(w_hdr_len);
              r_state <= S_LOAD;
            end else begin
              r_cnt   <= 7'(w_hdr_len) + 7'd1;
              r_drop  <= 1'b1;
              r_state <= S_DISCARD;
            end
          end
        end
        S_LOAD: begin
          if (w_flush4[r_dest]) begin
            r_cnt   <= w_acc ? r_cnt : r_cnt + 7'd1;
            r_drop  <= 1'b1;
            r_state <= S_DISCARD;
          end else if (w_acc) begin
            r_parity <= r_parity ^ data_in;
            r_cnt    <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_flush4[r_dest]) begin
            r_drop <= 1'b1;
            if (w_acc) begin
              r_state <= S_DECODE;
            end else begin
              r_cnt   <= 7'd1;
              r_state <= S_DISCARD;
            end
          end else if (w_acc) begin
            r_err   <= (r_parity != data_in);
            r_state <= S_DECODE;
          end
        end
        default: begin
          if (w_acc) begin
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) r_state <= S_DECODE;
          end
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      data_out[i*DATA_W +: DATA_W] = w_valid[i] ? r_mem[i][r_rptr[i][AW-1:0]] : '0;
    end
  end

  assign valid_out = w_valid;
  assign busy      = w_busy;
  assign err       = r_err;
  assign drop      = r_drop;

endmodule
